// File: rtl/armleo_pkg.sv
// Shared types for the armleo block family.
// Holds the packet-lock FSM state used by armleo_arb_mux.
package armleo_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/armleo_round_robin.sv
// Round-robin arbiter: highest priority starts at the rotation pointer,
// which moves just past the granted requester whenever ack is asserted.
module armleo_round_robin #(
  parameter int WIDTH = 4,
  localparam int IW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] request,
  input  logic             ack,
  output logic             grant_valid,
  output logic [IW-1:0]    grant_idx
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_nxt;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      int j;
      j = int'(ptr) + i;
      if (j >= WIDTH) j = j - WIDTH;
      if (!grant_valid && request[j]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(j);
      end
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    if (ack && grant_valid) begin
      if (grant_idx == IW'(WIDTH - 1)) ptr_nxt = '0;
      else ptr_nxt = grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr <= '0;
    else ptr <= ptr_nxt;
  end

endmodule

// File: rtl/armleo_arb_mux.sv
// N-to-1 arbitrated mux with a registered output stage (valid/ready).
// Optional packet lock compiled in with ARMLEO_ARB_MUX_LOCK_EN.
module armleo_arb_mux
  import armleo_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 32,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    in_valid,
  input  logic [N*DW-1:0] in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [IW-1:0]   out_idx,
  input  logic            out_ready
`ifdef ARMLEO_ARB_MUX_LOCK_EN
  ,
  input  logic [N-1:0]    in_last,
  output logic            out_last
`endif
);

  logic          rr_valid;
  logic [IW-1:0] rr_idx;
  logic          ack;
  logic          eligible;
  logic [IW-1:0] sel_idx;
  logic [DW-1:0] sel_data;
  logic          load;

  armleo_round_robin #(
    .WIDTH(N)
  ) u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .request    (in_valid),
    .ack        (ack),
    .grant_valid(rr_valid),
    .grant_idx  (rr_idx)
  );

`ifdef ARMLEO_ARB_MUX_LOCK_EN
  lock_state_t   state;
  lock_state_t   state_nxt;
  logic [IW-1:0] lock_port;
  logic [IW-1:0] lock_port_nxt;

  // While locked only the locked port may load and the arbiter is frozen.
  always_comb begin
    if (state == LOCKED) begin
      sel_idx  = lock_port;
      eligible = in_valid[lock_port];
    end else begin
      sel_idx  = rr_idx;
      eligible = rr_valid;
    end
    load = rst_n && (!out_valid || out_ready) && eligible;
    ack  = load && (state == ARB);
  end

  always_comb begin
    state_nxt     = state;
    lock_port_nxt = lock_port;
    case (state)
      ARB: begin
        if (load && !in_last[sel_idx]) begin
          state_nxt     = LOCKED;
          lock_port_nxt = sel_idx;
        end
      end
      LOCKED: begin
        if (load && in_last[lock_port]) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ARB;
      lock_port <= '0;
    end else begin
      state     <= state_nxt;
      lock_port <= lock_port_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) out_last <= 1'b0;
    else if (load) out_last <= in_last[sel_idx];
  end
`else
  always_comb begin
    sel_idx  = rr_idx;
    eligible = rr_valid;
    load     = rst_n && (!out_valid || out_ready) && eligible;
    ack      = load;
  end
`endif

  always_comb begin
    sel_data = in_data[sel_idx*DW +: DW];
    in_ready = '0;
    in_ready[sel_idx] = load;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_idx   <= sel_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
